// File: rtl/nibble_serial_adder_if.sv
// nibble_serial_adder_if: operand/result handshake bundle; carries ovf when NIBBLE_SERIAL_ADDER_OVF_EN is defined
interface nibble_serial_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             busy;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    logic             ovf;
    modport master (output in_valid, a, b, c_in, out_ready,
                    input  in_ready, out_valid, sum, c_out, busy, ovf);
    modport slave  (input  in_valid, a, b, c_in, out_ready,
                    output in_ready, out_valid, sum, c_out, busy, ovf);
`else
    modport master (output in_valid, a, b, c_in, out_ready,
                    input  in_ready, out_valid, sum, c_out, busy);
    modport slave  (input  in_valid, a, b, c_in, out_ready,
                    output in_ready, out_valid, sum, c_out, busy);
`endif
endinterface

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: WIDTH-bit add done one 4-bit lookahead slice per clock, LSB first; NIBBLE_SERIAL_ADDER_OVF_EN adds ovf
module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input logic                  clk,
    input logic                  rst,
    nibble_serial_adder_if.slave bus
);
    localparam int NSLICE = WIDTH / 4;
    localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [IW-1:0]    idx;
    logic             carry;
    logic             c_out_r;
    logic [WIDTH-1:0] a_r, b_r, sum_r;
    logic [3:0]       sa, sb, g, p, s;
    logic [4:0]       c;
    logic             last;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    logic             ovf_r;
`endif

    // Current slice of the captured operands through a 4-bit carry-lookahead adder
    always_comb begin
        sa   = a_r[{idx, 2'b00} +: 4];
        sb   = b_r[{idx, 2'b00} +: 4];
        g    = sa & sb;
        p    = sa ^ sb;
        c[0] = carry;
        c[1] = g[0] | (p[0] & c[0]);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c[0]);
        s    = p ^ c[3:0];
        last = (idx == IW'(NSLICE - 1));
    end

    // Capture operands in IDLE, fold in one slice per RUN edge, hold the result in DONE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            idx     <= '0;
            carry   <= 1'b0;
            a_r     <= '0;
            b_r     <= '0;
            sum_r   <= '0;
            c_out_r <= 1'b0;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
            ovf_r   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    a_r   <= bus.a;
                    b_r   <= bus.b;
                    carry <= bus.c_in;
                    idx   <= '0;
                    sum_r <= '0;
                    state <= RUN;
                end
                RUN: begin
                    sum_r[{idx, 2'b00} +: 4] <= s;
                    carry <= c[4];
                    if (last) begin
                        c_out_r <= c[4];
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
                        ovf_r   <= c[3] ^ c[4];
`endif
                        state   <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: if (bus.out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.busy      = (state != IDLE);
    assign bus.sum       = sum_r;
    assign bus.c_out     = c_out_r;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    assign bus.ovf       = ovf_r;
`endif
endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb_nibble_serial_adder: random and directed sums on WIDTH=16 and WIDTH=4 instances against an arithmetic model
module tb_nibble_serial_adder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vecs = 0;
    int   errs = 0;

    nibble_serial_adder_if #(.WIDTH(16)) bus16();
    nibble_serial_adder_if #(.WIDTH(4))  bus4();

    nibble_serial_adder #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));
    nibble_serial_adder #(.WIDTH(4))  dut4  (.clk(clk), .rst(rst), .bus(bus4));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Plain integer arithmetic: unsigned sum/carry and signed range overflow
    function automatic void model(input int w, input longint x, input longint y, input longint ci,
                                  output longint s, output bit co, output bit ov);
        longint t, xs, ys, ts;
        t  = x + y + ci;
        s  = t % (64'sd1 << w);
        co = (t >= (64'sd1 << w));
        xs = (x >= (64'sd1 << (w - 1))) ? x - (64'sd1 << w) : x;
        ys = (y >= (64'sd1 << (w - 1))) ? y - (64'sd1 << w) : y;
        ts = xs + ys + ci;
        ov = (ts > (64'sd1 << (w - 1)) - 1) || (ts < -(64'sd1 << (w - 1)));
    endfunction

    // Called just after the accepting edge; scrambles inputs and waits for the result
    task automatic finish16(input logic [15:0] x, input logic [15:0] y, input logic ci,
                            output longint s, output bit co);
        bit ov;
        int lat = 0;
        model(16, longint'(x), longint'(y), longint'(ci), s, co, ov);
        bus16.in_valid = 1'b0;
        bus16.a        = 16'($urandom);
        bus16.b        = 16'($urandom);
        bus16.c_in     = 1'($urandom);
        while (!bus16.out_valid && lat < 20) begin
            check("run_in_ready", bus16.in_ready, 0);
            check("run_busy", bus16.busy, 1);
            @(posedge clk); #1;
            lat++;
        end
        check("latency16", lat, 4);
        check("sum16", bus16.sum, s);
        check("c_out16", bus16.c_out, co);
        check("done_busy", bus16.busy, 1);
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
        check("ovf16", bus16.ovf, ov);
`endif
    endtask

    // Holds DONE for some cycles, then completes the handshake
    task automatic release16(input longint s, input bit co, input int hold);
        repeat (hold) begin
            @(posedge clk); #1;
            check("hold_valid", bus16.out_valid, 1);
            check("hold_in_ready", bus16.in_ready, 0);
            check("hold_sum", bus16.sum, s);
            check("hold_c_out", bus16.c_out, co);
        end
        bus16.out_ready = 1'b1;
        @(posedge clk); #1;
        bus16.out_ready = 1'b0;
        check("idle_in_ready", bus16.in_ready, 1);
        check("idle_valid", bus16.out_valid, 0);
        check("idle_busy", bus16.busy, 0);
        check("idle_sum_kept", bus16.sum, s);
        check("idle_c_out_kept", bus16.c_out, co);
    endtask

    task automatic add16(input logic [15:0] x, input logic [15:0] y, input logic ci, input int hold);
        longint s;
        bit co;
        @(negedge clk);
        bus16.a = x; bus16.b = y; bus16.c_in = ci; bus16.in_valid = 1'b1;
        check("pre_in_ready", bus16.in_ready, 1);
        @(posedge clk); #1;
        finish16(x, y, ci, s, co);
        release16(s, co, hold);
    endtask

    task automatic add4(input logic [3:0] x, input logic [3:0] y, input logic ci);
        longint s;
        bit co, ov;
        int lat = 0;
        model(4, longint'(x), longint'(y), longint'(ci), s, co, ov);
        @(negedge clk);
        bus4.a = x; bus4.b = y; bus4.c_in = ci; bus4.in_valid = 1'b1;
        check("pre_in_ready4", bus4.in_ready, 1);
        @(posedge clk); #1;
        bus4.in_valid = 1'b0;
        bus4.a = 4'($urandom);
        bus4.b = 4'($urandom);
        while (!bus4.out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency4", lat, 1);
        check("sum4", bus4.sum, s);
        check("c_out4", bus4.c_out, co);
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
        check("ovf4", bus4.ovf, ov);
`endif
        bus4.out_ready = 1'b1;
        @(posedge clk); #1;
        bus4.out_ready = 1'b0;
        check("idle_in_ready4", bus4.in_ready, 1);
    endtask

    initial begin
        longint s;
        bit co;
        bus16.in_valid = 0; bus16.a = 0; bus16.b = 0; bus16.c_in = 0; bus16.out_ready = 0;
        bus4.in_valid = 0;  bus4.a = 0;  bus4.b = 0;  bus4.c_in = 0;  bus4.out_ready = 0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", bus16.in_ready, 1);
        check("rst_valid", bus16.out_valid, 0);
        check("rst_busy", bus16.busy, 0);
        check("rst_sum", bus16.sum, 0);
        check("rst_c_out", bus16.c_out, 0);
        check("rst_in_ready4", bus4.in_ready, 1);
        rst = 1'b0;

        add16(16'hFFFF, 16'h0001, 1'b0, 0);
        add16(16'h1234, 16'h4321, 1'b1, 1);
        add16(16'h7FFF, 16'h0001, 1'b0, 0);
        add16(16'hFFFF, 16'hFFFF, 1'b1, 2);
        add16(16'h8000, 16'h8000, 1'b0, 0);

        // Backpressure with new operands offered throughout DONE
        @(negedge clk);
        bus16.a = 16'hABCD; bus16.b = 16'h1111; bus16.c_in = 1'b0; bus16.in_valid = 1'b1;
        @(posedge clk); #1;
        finish16(16'hABCD, 16'h1111, 1'b0, s, co);
        bus16.a = 16'h0F0F; bus16.b = 16'hF0F1; bus16.c_in = 1'b1; bus16.in_valid = 1'b1;
        release16(s, co, 5);
        @(posedge clk); #1;
        check("bp_accept_busy", bus16.busy, 1);
        finish16(16'h0F0F, 16'hF0F1, 1'b1, s, co);
        release16(s, co, 0);

        // Reset after the second slice edge aborts the operation
        @(negedge clk);
        bus16.a = 16'h9999; bus16.b = 16'h7777; bus16.c_in = 1'b1; bus16.in_valid = 1'b1;
        @(posedge clk); #1;
        bus16.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("abort_valid", bus16.out_valid, 0);
        check("abort_sum", bus16.sum, 0);
        check("abort_c_out", bus16.c_out, 0);
        check("abort_in_ready", bus16.in_ready, 1);
        check("abort_busy", bus16.busy, 0);
        @(negedge clk);
        rst = 1'b0;
        add16(16'h00FF, 16'h0001, 1'b0, 0);

        for (int i = 0; i < 20; i++)
            add16(16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 2)));

        add4(4'hF, 4'hF, 1'b1);
        add4(4'h7, 4'h1, 1'b0);
        for (int i = 0; i < 8; i++)
            add4(4'($urandom), 4'($urandom), 1'($urandom));

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
